// File: rtl/ethernet_tx_packet_sender.sv
// TX packet sender: single-slot byte-maskable packet buffer that is streamed
// byte-by-byte to the MAC over an AXI-Stream-style interface, with a TX
// completion event (pending/enable) reported back to the MMIO control unit.
module ethernet_tx_packet_sender #(
  parameter int unsigned eth_mtu_p    = 2048,
  parameter int unsigned data_width_p = 32,
  localparam int unsigned packet_size_width_lp = $clog2(eth_mtu_p + 1),
  localparam int unsigned packet_addr_width_lp = $clog2(eth_mtu_p)
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,

  // Buffer write port (from control unit)
  input  logic                            packet_wvalid_i,
  input  logic [packet_addr_width_lp-1:0] packet_waddr_i,
  input  logic [data_width_p-1:0]         packet_wdata_i,
  input  logic [data_width_p/8-1:0]       packet_wmask_i,

  // Length and send control
  input  logic                            packet_wsize_valid_i,
  input  logic [packet_size_width_lp-1:0] packet_wsize_i,
  input  logic                            packet_send_i,
  output logic                            packet_req_o,

  // TX event
  input  logic                            tx_interrupt_clear_i,
  input  logic                            tx_interrupt_enable_i,
  input  logic                            tx_interrupt_enable_v_i,
  output logic                            tx_interrupt_pending_o,
  output logic                            tx_interrupt_o,

  // Byte stream to the MAC
  output logic [7:0]                      m_axis_tdata_o,
  output logic                            m_axis_tvalid_o,
  output logic                            m_axis_tlast_o,
  input  logic                            m_axis_tready_i
);

  // Buffer geometry: 4 byte lanes per 32-bit word.
  localparam int unsigned bytes_per_word_lp    = data_width_p / 8;
  localparam int unsigned words_lp             = eth_mtu_p / bytes_per_word_lp;
  localparam int unsigned word_addr_width_lp   = packet_addr_width_lp - 2;

  localparam logic [packet_size_width_lp-1:0] mtu_size_lp = packet_size_width_lp'(eth_mtu_p);
  localparam logic [packet_size_width_lp-1:0] one_lp      = packet_size_width_lp'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e                          state_q, state_d;
  logic [packet_size_width_lp-1:0] size_q, size_d;
  logic [packet_size_width_lp-1:0] byte_cnt_q, byte_cnt_d;
  logic                            pending_q, pending_d;
  logic                            enable_q, enable_d;

  logic                            wr_en;
  logic                            rd_en;
  logic                            set_pending;
  logic                            req;
  logic                            tvalid;
  logic                            tlast;
  logic                            is_last;
  logic [packet_size_width_lp-1:0] byte_cnt_inc;
  logic [packet_size_width_lp-1:0] size_clamped;
  logic [word_addr_width_lp-1:0]   wr_word_addr;
  logic [word_addr_width_lp-1:0]   rd_word_addr;
  logic [data_width_p-1:0]         rd_word;
  logic [7:0]                      stream_byte;

  // The two LSBs of the write address select a byte inside a word; the mask
  // already carries that information, so they are intentionally ignored.
  logic unused_waddr_lsbs;
  assign unused_waddr_lsbs = ^packet_waddr_i[1:0];

  assign wr_word_addr = packet_waddr_i[packet_addr_width_lp-1:2];
  assign rd_word_addr = byte_cnt_q[packet_addr_width_lp-1:2];
  assign byte_cnt_inc = byte_cnt_q + one_lp;
  assign is_last      = (byte_cnt_q == (size_q - one_lp));
  assign size_clamped = (packet_wsize_i > mtu_size_lp) ? mtu_size_lp : packet_wsize_i;

  // Packet buffer: one RAM per byte lane so each lane has its own write
  // enable; reads are registered (1-cycle latency) and contents are never reset.
  for (genvar gi = 0; gi < bytes_per_word_lp; gi++) begin : g_lane
    logic [7:0] lane_mem_q [words_lp];
    logic [7:0] lane_rd_q;

    // Commit this lane's byte when the write is accepted and its mask bit is set.
    always_ff @(posedge clk_i) begin
      if (wr_en && packet_wmask_i[gi]) begin
        lane_mem_q[wr_word_addr] <= packet_wdata_i[8*gi +: 8];
      end
    end

    // Registered read of the word currently being streamed.
    always_ff @(posedge clk_i) begin
      if (rd_en) begin
        lane_rd_q <= lane_mem_q[rd_word_addr];
      end
    end

    assign rd_word[8*gi +: 8] = lane_rd_q;
  end

  // Little-endian byte select from the fetched word.
  always_comb begin
    stream_byte = 8'h00;
    case (byte_cnt_q[1:0])
      2'd0:    stream_byte = rd_word[7:0];
      2'd1:    stream_byte = rd_word[15:8];
      2'd2:    stream_byte = rd_word[23:16];
      default: stream_byte = rd_word[31:24];
    endcase
  end

  // Next-state and control decode for the send sequencer.
  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    byte_cnt_d  = byte_cnt_q;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    set_pending = 1'b0;
    req         = 1'b0;
    tvalid      = 1'b0;
    tlast       = 1'b0;

    case (state_q)
      IDLE: begin
        req   = 1'b1;
        wr_en = packet_wvalid_i;
        if (packet_wsize_valid_i) begin
          size_d = size_clamped;
        end
        if (packet_send_i) begin
          if (size_q == '0) begin
            state_d = DONE;
          end else begin
            byte_cnt_d = '0;
            state_d    = READ;
          end
        end
      end

      READ: begin
        rd_en   = 1'b1;
        state_d = STREAM;
      end

      STREAM: begin
        tvalid = 1'b1;
        tlast  = is_last;
        if (m_axis_tready_i) begin
          if (is_last) begin
            state_d = DONE;
          end else begin
            byte_cnt_d = byte_cnt_inc;
            // Crossing into a new word needs a fresh RAM read.
            if (byte_cnt_inc[1:0] == 2'b00) begin
              state_d = READ;
            end
          end
        end
      end

      DONE: begin
        set_pending = 1'b1;
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Interrupt bookkeeping: completion beats a simultaneous clear.
  always_comb begin
    pending_d = pending_q;
    enable_d  = enable_q;
    if (set_pending) begin
      pending_d = 1'b1;
    end else if (tx_interrupt_clear_i) begin
      pending_d = 1'b0;
    end
    if (tx_interrupt_enable_v_i) begin
      enable_d = tx_interrupt_enable_i;
    end
  end

  // Control state registers with asynchronous abort on reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      size_q     <= '0;
      byte_cnt_q <= '0;
      pending_q  <= 1'b0;
      enable_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      byte_cnt_q <= byte_cnt_d;
      pending_q  <= pending_d;
      enable_q   <= enable_d;
    end
  end

  assign packet_req_o           = req;
  assign m_axis_tvalid_o        = tvalid;
  assign m_axis_tlast_o         = tlast;
  assign m_axis_tdata_o         = tvalid ? stream_byte : 8'h00;
  assign tx_interrupt_pending_o = pending_q;
  assign tx_interrupt_o         = pending_q & enable_q;

`ifndef SYNTHESIS
  // Buffer writes while a packet is in flight are dropped; flag them.
  wr_outside_idle_a : assert property (
    @(posedge clk_i) disable iff (!reset_n_i)
    packet_wvalid_i |-> (state_q == IDLE)
  );
`endif

endmodule
